// File: rtl/cmp_pkg.sv
// cmp_pkg: shared widths, streak states and outcome indices for the compare stage
package cmp_pkg;
  localparam int OPW = 7;
  localparam int EQ_IDX = 2;
  localparam int GT_IDX = 1;
  localparam int LT_IDX = 0;
  typedef enum logic [1:0] {IDLE, RUN, HIT} streak_t;
endpackage

// File: rtl/comparator_7bit.sv
// comparator_7bit: unsigned magnitude compare producing one-hot eq/gt/lt
module comparator_7bit
  import cmp_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           eq,
  output logic           gt,
  output logic           lt
);
  assign eq = a == b;
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor: registered compare stage with saturating outcome counters and gt-streak detector
module cmp_result_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int STREAK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_a,
  output logic [OPW-1:0]   out_b,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic             streak_flag
);
  logic             eq, gt, lt, accept;
  logic [2:0]       hit;
  logic [CNT_W-1:0] cnt [3];
  logic [7:0]       run;
  streak_t          state;
  comparator_7bit u_cmp (.a(in_a), .b(in_b), .eq(eq), .gt(gt), .lt(lt));
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hit      = {eq, gt, lt};
  assign cnt_eq   = cnt[EQ_IDX];
  assign cnt_gt   = cnt[GT_IDX];
  assign cnt_lt   = cnt[LT_IDX];
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_eq    <= 1'b0;
      out_gt    <= 1'b0;
      out_lt    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= in_a;
      out_b     <= in_b;
      out_eq    <= eq;
      out_gt    <= gt;
      out_lt    <= lt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || clr) cnt[i] <= '0;
      else if (accept && hit[i] && !(&cnt[i])) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end
  // streak_flag is registered alongside state so it tracks HIT exactly
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state       <= IDLE;
      run         <= '0;
      streak_flag <= 1'b0;
    end else if (accept) begin
      if (!gt) begin
        state       <= IDLE;
        run         <= '0;
        streak_flag <= 1'b0;
      end else if (state == IDLE) begin
        state       <= (STREAK_N == 1) ? HIT : RUN;
        run         <= 8'd1;
        streak_flag <= STREAK_N == 1;
      end else if (state == RUN) begin
        run <= run + 8'd1;
        if (run + 8'd1 == 8'(STREAK_N)) begin
          state       <= HIT;
          streak_flag <= 1'b1;
        end
      end
    end
  end
  always @(posedge clk)
    if (!rst && out_valid) assert ($onehot({out_eq, out_gt, out_lt}));
endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor: scoreboard bench, 16-bit and 4-bit counter instances driven in parallel
module tb_cmp_result_monitor;
  logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
  logic [6:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_eq, out_gt, out_lt, streak_flag;
  logic [6:0] out_a, out_b;
  logic [15:0] cnt_eq, cnt_gt, cnt_lt;
  logic in_ready4, out_valid4, out_eq4, out_gt4, out_lt4, streak_flag4;
  logic [6:0] out_a4, out_b4;
  logic [3:0] cnt_eq4, cnt_gt4, cnt_lt4;
  int checks = 0, errors = 0;
  int ce = 0, cg = 0, cl = 0, c4e = 0, c4g = 0, c4l = 0, run = 0;
  bit ready_rand = 0;
  logic ready_fix = 1;
  typedef struct {
    logic [6:0] a, b;
    logic [2:0] f;
    int ce, cg, cl, c4e, c4g, c4l;
    logic fl;
  } exp_t;
  exp_t q[$];

  cmp_result_monitor u16 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_eq(out_eq), .out_gt(out_gt), .out_lt(out_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt),
    .streak_flag(streak_flag));
  cmp_result_monitor #(.CNT_W(4), .STREAK_N(4)) u4 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready4), .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
    .out_a(out_a4), .out_b(out_b4), .out_eq(out_eq4), .out_gt(out_gt4), .out_lt(out_lt4),
    .cnt_eq(cnt_eq4), .cnt_gt(cnt_gt4), .cnt_lt(cnt_lt4), .streak_flag(streak_flag4));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        chk("out_a", out_a, q[0].a);
        chk("out_b", out_b, q[0].b);
        chk("flags", {out_eq, out_gt, out_lt}, q[0].f);
        chk("cnt_eq", cnt_eq, q[0].ce);
        chk("cnt_gt", cnt_gt, q[0].cg);
        chk("cnt_lt", cnt_lt, q[0].cl);
        chk("streak_flag", streak_flag, q[0].fl);
        chk("cnt4_eq", cnt_eq4, q[0].c4e);
        chk("cnt4_gt", cnt_gt4, q[0].c4g);
        chk("cnt4_lt", cnt_lt4, q[0].c4l);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return v < mx ? v + 1 : mx;
  endfunction

  task automatic send(input logic [6:0] a, input logic [6:0] b, input logic [2:0] f, input logic c);
    exp_t e;
    int t = 0;
    in_valid = 1; in_a = a; in_b = b; clr = c;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    if (c) begin
      ce = 0; cg = 0; cl = 0; c4e = 0; c4g = 0; c4l = 0; run = 0;
    end else begin
      if (f[2]) begin ce = sat(ce, 65535); c4e = sat(c4e, 15); end
      if (f[1]) begin cg = sat(cg, 65535); c4g = sat(c4g, 15); end
      if (f[0]) begin cl = sat(cl, 65535); c4l = sat(c4l, 15); end
      run = f[1] ? sat(run, 255) : 0;
    end
    e = '{a: a, b: b, f: f, ce: ce, cg: cg, cl: cl, c4e: c4e, c4g: c4g, c4l: c4l, fl: run >= 4};
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0; clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    ready_rand = 0; ready_fix = 1;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  task automatic clear();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    ce = 0; cg = 0; cl = 0; c4e = 0; c4g = 0; c4l = 0; run = 0;
  endtask

  localparam logic [2:0] EQ = 3'b100, GT = 3'b010, LT = 3'b001;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ab", {out_a, out_b}, 0);
    chk("rst_flags", {out_eq, out_gt, out_lt}, 0);
    chk("rst_cnts", cnt_eq + cnt_gt + cnt_lt, 0);
    chk("rst_streak", streak_flag, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;
    send(7'd5, 7'd3, GT, 0);
    drain();
    chk("t2_cnt_gt", cnt_gt, 1);
    ready_fix = 0;
    send(7'd9, 7'd9, EQ, 0);
    fork
      send(7'd1, 7'd2, LT, 0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_a", out_a, 9);
        ready_fix = 1;
      end
    join
    drain();
    chk("t3_cnt_eq", cnt_eq, 1);
    chk("t3_cnt_lt", cnt_lt, 1);
    send(7'd10, 7'd1, GT, 0);
    send(7'd20, 7'd2, GT, 0);
    idle(2);
    send(7'd30, 7'd3, GT, 0);
    send(7'd127, 7'd0, GT, 0);
    idle(1);
    @(negedge clk);
    chk("streak_raised", streak_flag, 1);
    @(posedge clk); #1;
    send(7'd3, 7'd3, EQ, 0);
    send(7'd4, 7'd1, GT, 0);
    send(7'd5, 7'd1, GT, 0);
    send(7'd6, 7'd1, GT, 0);
    send(7'd0, 7'd1, LT, 0);
    drain();
    chk("streak_low", streak_flag, 0);
    clear();
    for (int i = 0; i < 17; i++) send(7'(i), 7'(i), EQ, 0);
    drain();
    chk("t5_cnt4_eq_sat", cnt_eq4, 15);
    chk("t5_cnt16_eq", cnt_eq, 17);
    send(7'd4, 7'd7, LT, 1);
    drain();
    chk("t5_clr_cnt4", cnt_eq4 + cnt_gt4 + cnt_lt4, 0);
    chk("t5_clr_cnt16", cnt_eq + cnt_gt + cnt_lt, 0);
    ready_rand = 1;
    for (int a = 0; a < 128; a++)
      for (int b = 0; b < 128; b++)
        send(7'(a), 7'(b), a == b ? EQ : (a > b ? GT : LT), 0);
    drain();
    chk("sweep_cnt_eq", cnt_eq, 128);
    chk("sweep_cnt_gt", cnt_gt, 8128);
    chk("sweep_cnt_lt", cnt_lt, 8128);
    chk("sweep_cnt4_gt", cnt_gt4, 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
